// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage access unit.
// Little-endian lanes: byte n = [8n+7:8n], half 0 = [15:0], half 1 = [31:16].
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    MS_WORD = 2'b00,
    MS_HALF = 2'b01,
    MS_BYTE = 2'b10,
    MS_RSVD = 2'b11
  } memSizeT;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } rmwStateT;

  // The reserved size encoding behaves exactly like a word access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic mis;
    case (size)
      MS_HALF: mis = addrLo[0];
      MS_BYTE: mis = 1'b0;
      default: mis = (addrLo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic isSubWord(input logic [1:0] size);
    return (size == MS_HALF) || (size == MS_BYTE);
  endfunction

  // Replace the addressed lane of oldWord with the low bits of newData.
  function automatic logic [31:0] mergeLane(input logic [31:0] oldWord,
                                            input logic [31:0] newData,
                                            input logic [1:0]  addrLo,
                                            input logic [1:0]  size);
    logic [31:0] merged;
    merged = oldWord;
    case (size)
      MS_BYTE: merged[{addrLo, 3'b000} +: 8]       = newData[7:0];
      MS_HALF: merged[{addrLo[1], 4'b0000} +: 16]  = newData[15:0];
      default: merged = newData;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the EX/MEM request, MEM/WB response and DataMemory signals.
// The access unit is the slave; pipeline plus memory together act as master.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = mem_pkg::MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::MEM_ADDR_WIDTH,
  parameter int CNT_WIDTH  = mem_pkg::MEM_CNT_WIDTH
);

  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemRead;
  logic                  MemWrite;
  logic [1:0]            MemSize;
  logic                  LoadSigned;

  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Stall;
  logic                  MisalignErr;
  logic [CNT_WIDTH-1:0]  RmwCount;

  logic [ADDR_WIDTH-1:0] DM_Address;
  logic [DATA_WIDTH-1:0] DM_WriteData;
  logic                  DM_MemWrite;
  logic                  DM_MemRead;
  logic [DATA_WIDTH-1:0] DM_ReadData;

  modport slave (
    input  Address, WriteData, MemRead, MemWrite, MemSize, LoadSigned, DM_ReadData,
    output ReadData, Stall, MisalignErr, RmwCount,
           DM_Address, DM_WriteData, DM_MemWrite, DM_MemRead
  );

  modport master (
    output Address, WriteData, MemRead, MemWrite, MemSize, LoadSigned, DM_ReadData,
    input  ReadData, Stall, MisalignErr, RmwCount,
           DM_Address, DM_WriteData, DM_MemWrite, DM_MemRead
  );

endinterface

// File: rtl/load_extract.sv
// Combinational load lane select with sign/zero extension of the selected
// byte or halfword; word and reserved sizes pass the memory word through.
module load_extract
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            addrLo,
  input  logic [1:0]            size,
  input  logic                  isSigned,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [7:0]  byteLane [LANES];
  logic [15:0] halfLane [LANES/2];
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gByte
      assign byteLane[gi] = word[8*gi +: 8];
    end
    for (gi = 0; gi < LANES/2; gi++) begin : gHalf
      assign halfLane[gi] = word[16*gi +: 16];
    end
  endgenerate

  always_comb begin
    selByte = byteLane[addrLo];
    selHalf = halfLane[addrLo[1]];
    case (size)
      MS_BYTE: result = {{(DATA_WIDTH-8){isSigned & selByte[7]}}, selByte};
      MS_HALF: result = {{(DATA_WIDTH-16){isSigned & selHalf[15]}}, selHalf};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: zero-latency loads, pass-through word stores and a
// two-state read-modify-write sequence for byte/halfword stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int CNT_WIDTH  = MEM_CNT_WIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_unit_if.slave  bus
);

  rmwStateT              stateReg;
  logic [DATA_WIDTH-1:0] mergeReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [CNT_WIDTH-1:0]  rmwCountReg;

  logic                  isStore;
  logic                  isLoad;
  logic                  subWord;
  logic                  misaligned;
  logic                  startRmw;
  logic [ADDR_WIDTH-1:0] alignedAddr;
  logic [DATA_WIDTH-1:0] loadValue;

  // A request with both strobes set is a store.
  assign isStore     = bus.MemWrite;
  assign isLoad      = bus.MemRead && !bus.MemWrite;
  assign subWord     = isSubWord(bus.MemSize);
  assign misaligned  = (isStore || isLoad) && isMisaligned(bus.MemSize, bus.Address[1:0]);
  assign alignedAddr = {bus.Address[ADDR_WIDTH-1:2], 2'b00};
  assign startRmw    = (stateReg == ST_IDLE) && isStore && subWord && !misaligned;

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) uExtract (
    .word     (bus.DM_ReadData),
    .addrLo   (bus.Address[1:0]),
    .size     (bus.MemSize),
    .isSigned (bus.LoadSigned),
    .result   (loadValue)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateReg    <= ST_IDLE;
      mergeReg    <= '0;
      addrReg     <= '0;
      rmwCountReg <= '0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (startRmw) begin
            mergeReg <= mergeLane(bus.DM_ReadData, bus.WriteData,
                                  bus.Address[1:0], bus.MemSize);
            addrReg  <= alignedAddr;
            stateReg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The merged word commits at this edge; the counter saturates.
          if (rmwCountReg != '1) begin
            rmwCountReg <= rmwCountReg + CNT_WIDTH'(1);
          end
          stateReg <= ST_IDLE;
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  assign bus.RmwCount = rmwCountReg;

  // Reset forces every strobe low at once so an in-flight RMW never writes.
  always_comb begin
    bus.ReadData     = '0;
    bus.Stall        = 1'b0;
    bus.MisalignErr  = 1'b0;
    bus.DM_Address   = '0;
    bus.DM_WriteData = '0;
    bus.DM_MemWrite  = 1'b0;
    bus.DM_MemRead   = 1'b0;
    if (!Reset) begin
      if (stateReg == ST_WRITE) begin
        bus.DM_Address   = addrReg;
        bus.DM_WriteData = mergeReg;
        bus.DM_MemWrite  = 1'b1;
      end else begin
        bus.DM_Address = alignedAddr;
        if (misaligned) begin
          bus.MisalignErr = 1'b1;
        end else if (isStore) begin
          if (subWord) begin
            bus.DM_MemRead = 1'b1;
            bus.Stall      = 1'b1;
          end else begin
            bus.DM_MemWrite  = 1'b1;
            bus.DM_WriteData = bus.WriteData;
          end
        end else if (isLoad) begin
          bus.DM_MemRead = 1'b1;
          bus.ReadData   = loadValue;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench: the driver updates a byte-level memory model and queues
// the expected event of each access; a monitor pops and compares DUT events.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int EV_NONE = 0;
  localparam int EV_LD   = 1;
  localparam int EV_WR   = 2;
  localparam int EV_MIS  = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } expT;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic memClear = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // DataMemory: combinational read, write on rising edge.
  logic [31:0] dmem [256];
  assign bus.DM_ReadData = dmem[bus.DM_Address[9:2]];
  always @(posedge Clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (bus.DM_MemWrite) begin
      dmem[bus.DM_Address[9:2]] <= bus.DM_WriteData;
    end
  end

  logic [31:0] refMem [256];
  expT         expQ [$];
  int          passCnt = 0;
  int          totalCnt = 0;
  int          expStalls = 0;
  int          seenStalls = 0;
  int          expRmw = 0;
  int          txnNum = 0;
  bit          monOn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] addr, input int nb, input bit sgn);
    logic [31:0] w;
    logic [31:0] v;
    int          sh;
    w = refMem[addr[9:2]];
    if (nb == 4) return w;
    sh = 8 * int'(addr[1:0]);
    v  = (w >> sh) & ((32'd1 << (8 * nb)) - 32'd1);
    if (sgn && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  task automatic refStore(input logic [31:0] addr, input int nb, input logic [31:0] data);
    logic [31:0] mask;
    int          sh;
    if (nb == 4) begin
      refMem[addr[9:2]] = data;
    end else begin
      sh   = 8 * int'(addr[1:0]);
      mask = ((32'd1 << (8 * nb)) - 32'd1) << sh;
      refMem[addr[9:2]] = (refMem[addr[9:2]] & ~mask) | ((data << sh) & mask);
    end
  endtask

  // Present one access and hold it until the DUT stops stalling.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, input bit sgn);
    int nb;
    int cyc;
    bit st;
    nb = sizeBytes(sz);
    if (rd || wr) begin
      if ((addr % nb) != 0) begin
        expQ.push_back('{EV_MIS, 32'h0, 32'h0});
      end else if (wr) begin
        refStore(addr, nb, wd);
        expQ.push_back('{EV_WR, addr & 32'hFFFF_FFFC, refMem[addr[9:2]]});
        if (nb < 4) begin
          expStalls++;
          expRmw++;
        end
      end else begin
        expQ.push_back('{EV_LD, 32'h0, refLoad(addr, nb, sgn)});
      end
    end
    $display("txn %0d: rd=%0d wr=%0d size=%0d addr=0x%02h wdata=0x%08h signed=%0d",
             txnNum, rd, wr, sz, addr[7:0], wd, sgn);
    txnNum++;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.MemSize    = sz;
    bus.Address    = addr;
    bus.WriteData  = wd;
    bus.LoadSigned = sgn;
    cyc = 0;
    do begin
      @(negedge Clk);
      st = bus.Stall;
      @(posedge Clk);
      #1;
      cyc++;
    end while (st && cyc < 4);
    chk("stall_release", {31'b0, st}, 32'h0);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // Monitor: classify what the DUT presents this cycle and score it.
  initial begin
    expT e;
    int  kind;
    forever begin
      @(negedge Clk);
      if (monOn && !Reset) begin
        if (bus.Stall) seenStalls++;
        if (bus.DM_MemWrite) kind = EV_WR;
        else if (bus.MisalignErr) kind = EV_MIS;
        else if (bus.MemRead && !bus.MemWrite) kind = EV_LD;
        else kind = EV_NONE;
        if (kind == EV_NONE) begin
          if (!bus.MemRead && !bus.MemWrite) begin
            chk("idle_readdata", bus.ReadData, 32'h0);
            chk("idle_strobes", {29'b0, bus.DM_MemRead, bus.DM_MemWrite, bus.Stall}, 32'h0);
          end
        end else if (expQ.size() == 0) begin
          chk("unexpected_event", kind, EV_NONE);
        end else begin
          e = expQ.pop_front();
          chk("event_kind", kind, e.kind);
          if (kind == e.kind) begin
            case (kind)
              EV_WR: begin
                chk("write_addr", bus.DM_Address, e.addr);
                chk("write_data", bus.DM_WriteData, e.data);
              end
              EV_LD: begin
                chk("load_data", bus.ReadData, e.data);
                chk("load_memread", {31'b0, bus.DM_MemRead}, 32'h1);
              end
              default: begin
                chk("misalign_readdata", bus.ReadData, 32'h0);
                chk("misalign_strobes", {30'b0, bus.DM_MemRead, bus.Stall}, 32'h0);
              end
            endcase
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          badWords;
    int          op;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 256; i++) refMem[i] = '0;
    bus.Address    = 32'h10;
    bus.WriteData  = 32'h0;
    bus.MemRead    = 1'b1;
    bus.MemWrite   = 1'b0;
    bus.MemSize    = 2'b00;
    bus.LoadSigned = 1'b0;

    // Reset state, with a load request pending on the inputs.
    repeat (3) @(posedge Clk);
    #3;
    chk("reset_readdata", bus.ReadData, 32'h0);
    chk("reset_strobes", {28'b0, bus.DM_MemRead, bus.DM_MemWrite, bus.Stall, bus.MisalignErr}, 32'h0);
    chk("reset_rmwcount", {16'b0, bus.RmwCount}, 32'h0);
    memClear = 1'b0;
    bus.MemRead = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    monOn = 1'b1;

    // Word store then load.
    issue(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 0);
    issue(1, 0, 2'b00, 32'h10, 32'h0, 0);
    chk("t1_no_stall", seenStalls, 0);

    // Sub-word loads.
    issue(0, 1, 2'b00, 32'h10, 32'h80FF7F01, 0);
    issue(1, 0, 2'b10, 32'h13, 32'h0, 1);
    issue(1, 0, 2'b10, 32'h13, 32'h0, 0);
    issue(1, 0, 2'b01, 32'h12, 32'h0, 1);

    // Byte store via read-modify-write.
    issue(0, 1, 2'b10, 32'h11, 32'h000000AA, 0);
    chk("t3_stalls", seenStalls, 1);
    chk("t3_rmwcount", {16'b0, bus.RmwCount}, 32'h1);
    issue(1, 0, 2'b00, 32'h10, 32'h0, 0);

    // Misaligned accesses.
    issue(1, 0, 2'b00, 32'h12, 32'h0, 0);
    issue(0, 1, 2'b01, 32'h11, 32'h0000BEEF, 0);
    issue(1, 0, 2'b00, 32'h10, 32'h0, 0);

    // Reset lands during the WRITE cycle of sh 0x1234 @0x20.
    $display("txn %0d: sh 0x1234 @0x20 with reset during write", txnNum);
    txnNum++;
    bus.Address   = 32'h20;
    bus.WriteData = 32'h1234;
    bus.MemSize   = 2'b01;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b1;
    expStalls++;
    @(negedge Clk);
    chk("t5_stall", {31'b0, bus.Stall}, 32'h1);
    @(posedge Clk);
    #2;
    chk("t5_write_pending", {31'b0, bus.DM_MemWrite}, 32'h1);
    Reset = 1'b1;
    #1;
    chk("t5_write_dropped", {31'b0, bus.DM_MemWrite}, 32'h0);
    chk("t5_rmwcount", {16'b0, bus.RmwCount}, 32'h0);
    @(posedge Clk);
    #1;
    bus.MemWrite = 1'b0;
    Reset = 1'b0;
    expRmw = 0;
    chk("t5_mem_unchanged", dmem[8], refMem[8]);
    issue(1, 0, 2'b00, 32'h20, 32'h0, 0);

    // Back-to-back byte stores into a zeroed word.
    issue(0, 1, 2'b10, 32'h30, 32'h00000011, 0);
    issue(0, 1, 2'b10, 32'h31, 32'h00000022, 0);
    chk("t6_rmwcount", {16'b0, bus.RmwCount}, 32'h2);
    issue(1, 0, 2'b00, 32'h30, 32'h0, 0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      op   = int'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sizeBytes(sz) - 1);
      issue(op[0], op[1], sz, addr, $urandom, 1'($urandom_range(0, 1)));
    end

    issue(0, 0, 2'b00, 32'h0, 32'h0, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("queue_drained", expQ.size(), 0);
    chk("stall_cycles", seenStalls, expStalls);
    chk("final_rmwcount", {16'b0, bus.RmwCount}, expRmw);
    badWords = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== refMem[i]) badWords++;
    chk("memory_image", badWords, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
